// File: rtl/seq_alu.sv
// Handshaked sequential ALU: registered base ops plus an optional iterative multiply/divide unit.
// Define SEQ_ALU_MULDIV_EN to build ops 8-13; otherwise they decode as illegal.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       aluOp,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegalOp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] base_res;
    logic [SHW-1:0]   shamt;
    logic             op_illegal;
    logic             op_muldiv;
    logic             last_iter;
    logic [WIDTH-1:0] md_result;
    logic             accept;

    assign accept = (state_q == S_IDLE) && inValid;
    assign shamt  = operand2[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (aluOp)
            OP_ADD:  base_res = operand1 + operand2;
            OP_SUB:  base_res = operand1 - operand2;
            OP_AND:  base_res = operand1 & operand2;
            OP_OR:   base_res = operand1 | operand2;
            OP_XOR:  base_res = operand1 ^ operand2;
            OP_SLL:  base_res = operand1 << shamt;
            OP_SRL:  base_res = operand1 >> shamt;
            OP_SRA:  base_res = WIDTH'($signed(operand1) >>> shamt);
            default: base_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    logic [3:0]       op_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, opb_q;
    logic             qneg_q, rneg_q;

    logic [WIDTH-1:0] hi_n, lo_n;
    logic [WIDTH:0]   mul_sum, div_sh, div_trial;
    logic             is_div_q;
    logic             in_div, in_signed;
    logic [WIDTH-1:0] mag1, mag2;

    assign op_illegal = (aluOp[3:1] == 3'b111);
    assign op_muldiv  = aluOp[3] && !op_illegal;
    assign last_iter  = (state_q == S_BUSY) && (cnt_q == SHW'(WIDTH - 1));
    assign is_div_q   = op_q[3] && (op_q[2] || op_q[1]);

    assign in_div    = aluOp[2] || aluOp[1];
    assign in_signed = (aluOp[3:1] == 3'b110);
    assign mag1      = (in_signed && operand1[WIDTH-1]) ? -operand1 : operand1;
    assign mag2      = (in_signed && operand2[WIDTH-1]) ? -operand2 : operand2;

    // Multiply keeps {hi,lo} as the running product; divide keeps remainder in hi, quotient shifting into lo.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + ({(WIDTH+1){lo_q[0]}} & {1'b0, opb_q});
        div_sh    = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_sh - {1'b0, opb_q};
        if (is_div_q) begin
            if (!div_trial[WIDTH]) begin
                hi_n = div_trial[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = div_sh[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        case (op_q)
            4'd8:    md_result = lo_n;
            4'd9:    md_result = hi_n;
            4'd10:   md_result = lo_n;
            4'd11:   md_result = hi_n;
            4'd12:   md_result = qneg_q ? -lo_n : lo_n;
            4'd13:   md_result = rneg_q ? -hi_n : hi_n;
            default: md_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (accept && op_muldiv) begin
            op_q   <= aluOp;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= in_div ? mag1 : operand2;
            opb_q  <= in_div ? mag2 : operand1;
            // A zero divisor must leave the all-ones quotient unsigned.
            qneg_q <= in_signed && (operand1[WIDTH-1] ^ operand2[WIDTH-1]) && (operand2 != '0);
            rneg_q <= in_signed && operand1[WIDTH-1];
        end else if (state_q == S_BUSY) begin
            cnt_q <= cnt_q + SHW'(1);
            hi_q  <= hi_n;
            lo_q  <= lo_n;
        end
    end
`else
    assign op_illegal = aluOp[3];
    assign op_muldiv  = 1'b0;
    assign last_iter  = 1'b0;
    assign md_result  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (inValid) state_d = op_muldiv ? S_BUSY : S_DONE;
            S_BUSY:  if (last_iter) state_d = S_DONE;
            S_DONE:  if (outReady) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        if (accept && !op_muldiv) begin
            result_d  = op_illegal ? '0 : base_res;
            illegal_d = op_illegal;
            zero_d    = (result_d == '0);
        end else if (last_iter) begin
            result_d  = md_result;
            illegal_d = 1'b0;
            zero_d    = (result_d == '0);
        end
    end

    always_comb begin
        inReady   = (state_q == S_IDLE);
        outValid  = (state_q == S_DONE);
        result    = result_q;
        zero      = zero_q;
        illegalOp = illegal_q;
    end

endmodule
